ecc_ram_scrubber: RTL and testbench
===================================

# ecc_ram_scrubber

Controller that sits in front of one `ecc_ram` instance and owns all of its port signals. It arbitrates between a single host request port and a background scrubber that periodically reads every word. Any read that reports a correctable error triggers a write-back of the corrected word. The block also keeps error statistics and raises an interrupt on uncorrectable errors.

## Interface
- `DATA_WIDTH`, 8: word width; 8 or 16, matching the RAM.
- `RAM_DEPTH`, 256: number of words. Local `AW = $clog2(RAM_DEPTH)`.
- `SCRUB_INTERVAL`, 1024: enabled cycles between scrub requests; must be ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `host_req`  in  1  host request valid.
- `host_we`  in  1  1 = write, 0 = read.
- `host_addr`  in  AW  host address.
- `host_wdata`  in  DATA_WIDTH  host write data.
- `host_ready`  out  1  request accepted on the edge where `host_req && host_ready`.
- `host_rvalid`  out  1  one-cycle pulse; read data valid.
- `host_rdata`  out  DATA_WIDTH  (corrected) read data.
- `host_sbe`, `host_dbe`  out  1  error flags accompanying `host_rvalid`.
- `scrub_en`  in  1  enables the scrub interval counter.
- `err_clr`  in  1  synchronous clear of the counters and `dbe_addr`.
- `ram_addr`  out  AW;  `ram_wdata`  out  DATA_WIDTH;  `ram_we`, `ram_re`  out  1  drive the RAM.
- `ram_rdata`  in  DATA_WIDTH;  `ram_sbe`, `ram_dbe`  in  1  RAM registered outputs, valid the cycle after `ram_re`.
- `sbe_count`, `dbe_count`  out  16  saturating error counters.
- `dbe_addr`  out  AW  address of the most recent uncorrectable error.
- `dbe_irq`  out  1  one-cycle pulse per uncorrectable error.
- `scrub_done`  out  1  one-cycle pulse when a full scrub pass completes.

## Operation
- States: IDLE, HWR, HRD, RDWAIT, WB, SRD.
- `ram_we = HWR|WB` and `ram_re = HRD|SRD`, decoded from state. `ram_addr`/`ram_wdata` come from a latched command register.
- IDLE arbitration, with a `last_grant` bit (reset = scrub):
  - Only host pending → host.
  - Only `scrub_pending` → scrub.
  - Both pending → opposite of `last_grant`.
- `host_ready = (state==IDLE) && !(scrub_pending && last_grant==host)`.
- Host accept:
  - Latch addr and data.
  - Go to HWR if `host_we`, else HRD.
  - Set `last_grant` = host.
- Scrub grant:
  - Latch `scrub_addr`, clear `scrub_pending`, set `last_grant` = scrub, go to SRD.
- HWR: one RAM write cycle → IDLE.
- HRD/SRD: one RAM read cycle → RDWAIT. An origin bit records host vs scrub.
- RDWAIT: sample `ram_rdata`/`ram_sbe`/`ram_dbe`.
  - Host origin: register `host_rdata`/`host_sbe`/`host_dbe` and pulse `host_rvalid` next cycle.
  - `ram_sbe` set: latch `ram_rdata` as write-back data, increment `sbe_count`, go to WB.
  - `ram_dbe` set: increment `dbe_count`, load `dbe_addr`, pulse `dbe_irq`, go to IDLE; no write.
  - Otherwise → IDLE.
- WB: one RAM write of the corrected word to the same address → IDLE.
- Scrub origin, leaving RDWAIT or WB: `scrub_addr` increments; `RAM_DEPTH-1` wraps to 0 and pulses `scrub_done`.
- Interval counter:
  - Counts while `scrub_en && !scrub_pending`.
  - At `SCRUB_INTERVAL-1`, sets `scrub_pending` and returns to 0.
- `scrub_en`=0: counter and `scrub_pending` are cleared. An in-flight scrub completes.
- Counters saturate at 0xFFFF.
- `err_clr` zeroes both counters and `dbe_addr`; clear wins over a same-cycle increment.

## Timing
- Reset: all registered outputs 0, state IDLE, `scrub_addr` 0, interval counter 0.
- `rst_n` low forces IDLE asynchronously, so `ram_we`/`ram_re` drop immediately. An in-flight write-back is abandoned. `host_ready` = 1 while in IDLE; requests during reset are ignored.
- Host write: accept edge E0 → `ram_we` high in cycle E0–E1. `host_ready` high again from E1.
- Host read: accept E0 → `ram_re` in E0–E1 → RDWAIT E1–E2 → `host_rvalid` high E2–E3.
  - Clean read: IDLE at E2, next accept possible at E2.
  - SBE: WB in E2–E3, `host_ready` low until E3.
- Scrub read has the same cadence, with no `host_rvalid`.
- With both continuously pending, grants strictly alternate.

## Test plan
- Host write 0xA5 to 0x10, then read 0x10 → `ram_we` one cycle; `host_rvalid` 2 cycles after read accept, `host_rdata`=0xA5, sbe=dbe=0, no WB.
- Read 0x20 with RAM model returning `ram_sbe`=1, data 0x3C → `host_rdata`=0x3C, `host_sbe`=1; next cycle `ram_we`=1 @0x20 with 0x3C; `sbe_count`=1; `host_ready` low that cycle.
- Scrub read of 0x05 returns `ram_dbe`=1 → no write, `dbe_count`=1, `dbe_addr`=0x05, `dbe_irq` one cycle; then `err_clr` → counts 0.
- `RAM_DEPTH`=4, `SCRUB_INTERVAL`=4, `scrub_en`=1, no host traffic → scrub reads 0,1,2,3 spaced by interval; `scrub_done` pulses after addr 3; next scrub reads 0.
- `host_req` held high with `scrub_pending` → host/scrub grants alternate; `host_ready` low only in IDLE cycles owed to scrub.
- `rst_n` asserted during WB → `ram_we` falls within the same cycle; all counters and outputs read 0 after release.

Source files
------------

// File: rtl/ecc_ram_scrubber.sv
// ECC RAM front-end: arbitrates host accesses against a periodic background
// scrubber, writes corrected words back and keeps error statistics.
module ecc_ram_scrubber #(
  parameter int DATA_WIDTH     = 8,
  parameter int RAM_DEPTH      = 256,
  parameter int SCRUB_INTERVAL = 1024,
  localparam int AW            = $clog2(RAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [AW-1:0]         host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_ready,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_sbe,
  output logic                  host_dbe,
  input  logic                  scrub_en,
  input  logic                  err_clr,
  output logic [AW-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  input  logic                  ram_sbe,
  input  logic                  ram_dbe,
  output logic [15:0]           sbe_count,
  output logic [15:0]           dbe_count,
  output logic [AW-1:0]         dbe_addr,
  output logic                  dbe_irq,
  output logic                  scrub_done,
  output logic [2:0]            dbg_state
);

  localparam int CW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HWR    = 3'd1;
  localparam logic [2:0] S_HRD    = 3'd2;
  localparam logic [2:0] S_RDWAIT = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_SRD    = 3'd5;

  logic [2:0]            state;
  logic                  last_grant;   // 1 = host won the previous grant
  logic                  origin_host;
  logic                  scrub_pending;
  logic [CW-1:0]         int_cnt;
  logic [AW-1:0]         scrub_addr;
  logic [AW-1:0]         cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic host_accept, scrub_grant, rd_wait, sbe_hit, dbe_hit, scrub_finish;

  // Handshake: a host command transfers on every rising edge where
  // host_req && host_ready; host_rvalid is a single-cycle pulse with no backpressure.
  assign host_ready   = (state == S_IDLE) && !(scrub_pending && last_grant);
  assign host_accept  = host_req && host_ready;
  assign scrub_grant  = (state == S_IDLE) && scrub_pending && !(host_req && !last_grant);
  assign rd_wait      = (state == S_RDWAIT);
  assign sbe_hit      = rd_wait && ram_sbe;
  assign dbe_hit      = rd_wait && !ram_sbe && ram_dbe;
  assign scrub_finish = !origin_host && ((rd_wait && !ram_sbe) || (state == S_WB));

  assign ram_we    = (state == S_HWR) || (state == S_WB);
  assign ram_re    = (state == S_HRD) || (state == S_SRD);
  assign ram_addr  = cmd_addr;
  assign ram_wdata = cmd_wdata;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      last_grant  <= 1'b0;
      origin_host <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (host_accept) begin
            cmd_addr    <= host_addr;
            cmd_wdata   <= host_wdata;
            origin_host <= 1'b1;
            last_grant  <= 1'b1;
            state       <= host_we ? S_HWR : S_HRD;
          end else if (scrub_grant) begin
            cmd_addr    <= scrub_addr;
            origin_host <= 1'b0;
            last_grant  <= 1'b0;
            state       <= S_SRD;
          end
        end
        S_HRD, S_SRD: state <= S_RDWAIT;
        S_RDWAIT: begin
          if (ram_sbe) begin
            cmd_wdata <= ram_rdata;
            state     <= S_WB;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
      host_sbe    <= 1'b0;
      host_dbe    <= 1'b0;
      dbe_irq     <= 1'b0;
    end else begin
      host_rvalid <= rd_wait && origin_host;
      dbe_irq     <= dbe_hit;
      if (rd_wait && origin_host) begin
        host_rdata <= ram_rdata;
        host_sbe   <= ram_sbe;
        host_dbe   <= ram_dbe;
      end
    end
  end

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbe_count <= '0;
      dbe_count <= '0;
      dbe_addr  <= '0;
    end else if (err_clr) begin
      sbe_count <= '0;
      dbe_count <= '0;
      dbe_addr  <= '0;
    end else begin
      if (sbe_hit && sbe_count != 16'hFFFF) sbe_count <= sbe_count + 16'd1;
      if (dbe_hit && dbe_count != 16'hFFFF) dbe_count <= dbe_count + 16'd1;
      if (dbe_hit) dbe_addr <= cmd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scrub_addr <= '0;
      scrub_done <= 1'b0;
    end else begin
      scrub_done <= scrub_finish && (scrub_addr == AW'(RAM_DEPTH - 1));
      if (scrub_finish) begin
        if (scrub_addr == AW'(RAM_DEPTH - 1)) scrub_addr <= '0;
        else                                   scrub_addr <= scrub_addr + 1'b1;
      end
    end
  end

  // The interval counter pauses while a request is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_cnt       <= '0;
      scrub_pending <= 1'b0;
    end else if (!scrub_en) begin
      int_cnt       <= '0;
      scrub_pending <= 1'b0;
    end else if (scrub_grant) begin
      scrub_pending <= 1'b0;
    end else if (!scrub_pending) begin
      if (int_cnt == CW'(SCRUB_INTERVAL - 1)) begin
        int_cnt       <= '0;
        scrub_pending <= 1'b1;
      end else begin
        int_cnt <= int_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ecc_ram_scrubber.sv
// Bench for ecc_ram_scrubber: a 256-word instance for host/ECC/arbitration
// behaviour and a 4-word instance for full scrub passes.
module tb_ecc_ram_scrubber;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int IVL = 8;
  localparam int S_AW = 2;
  localparam int S_IVL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // large instance
  logic          host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_ready, host_rvalid, host_sbe, host_dbe;
  logic [DW-1:0] host_rdata;
  logic          scrub_en = 1'b0, err_clr = 1'b0;
  logic [AW-1:0] ram_addr, dbe_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we, ram_re;
  logic [DW-1:0] ram_rdata = '0;
  logic          ram_sbe = 1'b0, ram_dbe = 1'b0;
  logic [15:0]   sbe_count, dbe_count;
  logic          dbe_irq, scrub_done;
  logic [2:0]    dbg_state;

  // small instance
  logic            s_scrub_en = 1'b0;
  logic            s_host_ready, s_host_rvalid, s_host_sbe, s_host_dbe;
  logic [DW-1:0]   s_host_rdata, s_ram_wdata;
  logic [S_AW-1:0] s_ram_addr, s_dbe_addr;
  logic            s_ram_we, s_ram_re, s_dbe_irq, s_scrub_done;
  logic [15:0]     s_sbe_count, s_dbe_count;
  logic [2:0]      s_dbg_state;

  ecc_ram_scrubber #(.DATA_WIDTH(DW), .RAM_DEPTH(256), .SCRUB_INTERVAL(IVL)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ready(host_ready), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_sbe(host_sbe), .host_dbe(host_dbe),
    .scrub_en(scrub_en), .err_clr(err_clr),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata), .ram_sbe(ram_sbe), .ram_dbe(ram_dbe),
    .sbe_count(sbe_count), .dbe_count(dbe_count), .dbe_addr(dbe_addr),
    .dbe_irq(dbe_irq), .scrub_done(scrub_done), .dbg_state(dbg_state)
  );

  ecc_ram_scrubber #(.DATA_WIDTH(DW), .RAM_DEPTH(4), .SCRUB_INTERVAL(S_IVL)) u_small (
    .clk(clk), .rst_n(rst_n),
    .host_req(1'b0), .host_we(1'b0), .host_addr(2'b00), .host_wdata(8'h00),
    .host_ready(s_host_ready), .host_rvalid(s_host_rvalid), .host_rdata(s_host_rdata),
    .host_sbe(s_host_sbe), .host_dbe(s_host_dbe),
    .scrub_en(s_scrub_en), .err_clr(1'b0),
    .ram_addr(s_ram_addr), .ram_wdata(s_ram_wdata), .ram_we(s_ram_we), .ram_re(s_ram_re),
    .ram_rdata(8'h00), .ram_sbe(1'b0), .ram_dbe(1'b0),
    .sbe_count(s_sbe_count), .dbe_count(s_dbe_count), .dbe_addr(s_dbe_addr),
    .dbe_irq(s_dbe_irq), .scrub_done(s_scrub_done), .dbg_state(s_dbg_state)
  );

  // RAM model: returns the stored (corrected) word on SBE, an inverted word on DBE.
  bit [DW-1:0] mem [256];
  bit          sbe_map [256];
  bit          dbe_map [256];
  logic          inj_sbe = 1'b0, inj_dbe = 1'b0;
  logic [AW-1:0] inj_addr = '0;

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr]     <= ram_wdata;
      sbe_map[ram_addr] <= 1'b0;
      dbe_map[ram_addr] <= 1'b0;
    end
    if (inj_sbe) sbe_map[inj_addr] <= 1'b1;
    if (inj_dbe) dbe_map[inj_addr] <= 1'b1;
    if (ram_re) begin
      ram_rdata <= dbe_map[ram_addr] ? ~mem[ram_addr] : mem[ram_addr];
      ram_sbe   <= sbe_map[ram_addr];
      ram_dbe   <= dbe_map[ram_addr];
    end
  end

  // Reference model (transaction level)
  bit [DW-1:0] ref_mem [256];
  bit          ref_s [256];
  bit          ref_d [256];
  int          ref_sbe_cnt = 0, ref_dbe_cnt = 0;
  logic [AW-1:0] ref_dbe_addr = '0;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic inject(input logic [AW-1:0] a, input logic s, input logic d);
    @(negedge clk);
    inj_addr = a; inj_sbe = s; inj_dbe = d;
    @(negedge clk);
    inj_sbe = 1'b0; inj_dbe = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " host_ready"}, host_ready, 1'b1);
    check({tag, " ram_we"}, ram_we, 1'b0);
    check({tag, " ram_re"}, ram_re, 1'b0);
    check({tag, " host_rvalid"}, host_rvalid, 1'b0);
    check({tag, " host_rdata"}, host_rdata, '0);
    check({tag, " sbe_count"}, sbe_count, '0);
    check({tag, " dbe_count"}, dbe_count, '0);
    check({tag, " dbe_addr"}, dbe_addr, '0);
    check({tag, " dbe_irq"}, dbe_irq, 1'b0);
    check({tag, " scrub_done"}, scrub_done, 1'b0);
  endtask

  // One host command; returns at the negedge of the cycle after host_rvalid
  // rises for reads (the write-back cycle when an SBE was reported).
  task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] er, input logic es, input logic ed,
                         input string tag);
    int n;
    @(negedge clk);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
    n = 0;
    while (!host_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      check({tag, " accept timeout"}, 32'(n), 0);
      host_req = 1'b0;
      return;
    end
    @(negedge clk);
    host_req = 1'b0;
    if (we) begin
      check({tag, " ram_we"}, ram_we, 1'b1);
      check({tag, " wr addr"}, ram_addr, a);
      check({tag, " wr data"}, ram_wdata, wd);
      @(negedge clk);
      if (!scrub_en) check({tag, " ready after wr"}, host_ready, 1'b1);
    end else begin
      check({tag, " ram_re"}, ram_re, 1'b1);
      check({tag, " rd addr"}, ram_addr, a);
      @(negedge clk);
      check({tag, " rvalid early"}, host_rvalid, 1'b0);
      @(negedge clk);
      check({tag, " rvalid"}, host_rvalid, 1'b1);
      check({tag, " rdata"}, host_rdata, er);
      check({tag, " sbe"}, host_sbe, es);
      check({tag, " dbe"}, host_dbe, ed);
      check({tag, " dbe_irq"}, dbe_irq, ed);
      if (es) begin
        check({tag, " wb we"}, ram_we, 1'b1);
        check({tag, " wb addr"}, ram_addr, a);
        check({tag, " wb data"}, ram_wdata, er);
        check({tag, " ready in wb"}, host_ready, 1'b0);
      end else begin
        check({tag, " no wb"}, ram_we, 1'b0);
      end
    end
  endtask

  task automatic do_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic is, input logic id,
                       input logic [DW-1:0] er, input logic es, input logic ed,
                       input string tag);
    if (is || id) inject(a, is, id);
    host_op(we, a, wd, er, es, ed, tag);
    if (we) begin
      ref_mem[a] = wd; ref_s[a] = 1'b0; ref_d[a] = 1'b0;
    end else begin
      if (es) begin ref_s[a] = 1'b0; ref_sbe_cnt++; end
      if (ed) begin ref_dbe_cnt++; ref_dbe_addr = a; end
    end
    check({tag, " sbe_count"}, sbe_count, ref_sbe_cnt);
    check({tag, " dbe_count"}, dbe_count, ref_dbe_cnt);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          inj_s;
    logic          inj_d;
    logic [DW-1:0] exp_rdata;
    logic          exp_s;
    logic          exp_d;
  } vec_t;

  vec_t vecs [12];
  logic [S_AW-1:0] exp_q [$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd3_cyc, last_rd, done_cnt, we_cnt, rv_cnt, n;
    int n_scrub, n_host;
    logic prev_ready, last_was_scrub, found;
    logic we, is, id, es, ed;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, er;

    vecs[0]  = '{1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h20, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h30, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h30, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};

    // reset: requests during reset are ignored
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h44;
    repeat (3) begin
      @(negedge clk);
      check("rst ram_we", ram_we, 1'b0);
      check("rst ram_re", ram_re, 1'b0);
    end
    host_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");

    // four-word scrub passes
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    s_scrub_en = 1'b1;
    last_rd = -1; rd3_cyc = -100; done_cnt = 0; we_cnt = 0; rv_cnt = 0;
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (s_ram_re) begin
        check("small scrub addr", s_ram_addr, exp_q.pop_front());
        if (last_rd < 0) check("small first scrub", c, S_IVL);
        else             check("small spacing", c - last_rd, S_IVL + 1);
        last_rd = c;
        if (s_ram_addr == 2'd3) rd3_cyc = c;
      end
      if (s_scrub_done) begin
        done_cnt++;
        check("small done after addr3", c - rd3_cyc, 2);
      end
      if (s_ram_we) we_cnt++;
      if (s_host_rvalid) rv_cnt++;
    end
    check("small all reads seen", exp_q.size(), 0);
    check("small done count", done_cnt, 1);
    check("small no writes", we_cnt, 0);
    check("small no rvalid", rv_cnt, 0);
    s_scrub_en = 1'b0;

    // directed vectors
    for (int i = 0; i < 12; i++)
      do_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].inj_s, vecs[i].inj_d,
            vecs[i].exp_rdata, vecs[i].exp_s, vecs[i].exp_d, $sformatf("vec%0d", i));
    check("vec dbe_addr", dbe_addr, ref_dbe_addr);

    // randomized traffic against the reference model
    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = 8'h40 + 8'($urandom_range(0, 7));
      wd = 8'($urandom);
      n  = $urandom_range(0, 7);
      is = !we && n == 0 && !ref_d[a];
      id = !we && n == 1 && !ref_s[a];
      es = ref_s[a] | is;
      ed = (ref_d[a] | id) & !es;
      er = ed ? ~ref_mem[a] : ref_mem[a];
      if (is) ref_s[a] = 1'b1;
      if (id) ref_d[a] = 1'b1;
      do_op(we, a, wd, is, id, er, es, ed, $sformatf("rnd%0d", i));
    end
    check("rnd dbe_addr", dbe_addr, ref_dbe_addr);

    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    ref_sbe_cnt = 0; ref_dbe_cnt = 0;
    check("clr sbe_count", sbe_count, 0);
    check("clr dbe_count", dbe_count, 0);
    check("clr dbe_addr", dbe_addr, 0);

    // scrub hits an uncorrectable word at 0x05
    inject(8'h05, 1'b0, 1'b1);
    scrub_en = 1'b1;
    found = 1'b0; we_cnt = 0; rv_cnt = 0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      if (ram_we) we_cnt++;
      if (host_rvalid) rv_cnt++;
      if (ram_re && ram_addr == 8'h05) found = 1'b1;
    end
    check("scrub reached 0x05", found, 1'b1);
    @(negedge clk);
    check("scrub dbe no irq yet", dbe_irq, 1'b0);
    @(negedge clk);
    check("scrub dbe irq", dbe_irq, 1'b1);
    check("scrub dbe count", dbe_count, 1);
    check("scrub dbe addr", dbe_addr, 8'h05);
    check("scrub dbe no write", ram_we, 1'b0);
    @(negedge clk);
    check("scrub dbe irq one cycle", dbe_irq, 1'b0);
    check("scrub no writes", we_cnt, 0);
    check("scrub no rvalid", rv_cnt, 0);
    scrub_en = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("scrub clr dbe_count", dbe_count, 0);
    check("scrub clr dbe_addr", dbe_addr, 0);

    // arbitration: host held pending while the scrubber runs
    repeat (4) @(negedge clk);
    scrub_en = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h80;
    prev_ready = host_ready; last_was_scrub = 1'b0; n_scrub = 0; n_host = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (ram_re) begin
        if (ram_addr != 8'h80) begin
          n_scrub++;
          check("arb ready low when scrub owed", prev_ready, 1'b0);
          check("arb alternate", last_was_scrub, 1'b0);
          last_was_scrub = 1'b1;
        end else begin
          n_host++;
          check("arb host accepted", prev_ready, 1'b1);
          last_was_scrub = 1'b0;
        end
      end
      prev_ready = host_ready;
    end
    host_req = 1'b0;
    scrub_en = 1'b0;
    check("arb scrub grants seen", n_scrub > 0, 1'b1);
    check("arb host grants exceed scrub", n_host > n_scrub, 1'b1);
    repeat (4) @(negedge clk);

    // reset during write-back
    do_op(1'b0, 8'h90, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "wb reset");
    #1 rst_n = 1'b0;
    #1;
    check("async rst ram_we", ram_we, 1'b0);
    check("async rst ram_re", ram_re, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post-rst");
    check("post-rst host_sbe", host_sbe, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
